// File: rtl/lcb_answer_pkg.sv
// lcb_answer_pkg: shared types and constants for the LCB answer table.
//   - cap_state_t    : UART capture FSM states
//   - *_OFS          : capture/status slot offsets, relative to N_CONST
//   - STAT_*_BIT     : bit positions inside the STAT word
package lcb_answer_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SAMPLE   = 2'd1,
      WAIT_LOW = 2'd2
   } cap_state_t;

   localparam int CAP_LO_OFS = 1;
   localparam int CAP_HI_OFS = 2;
   localparam int STAT_OFS   = 3;

   localparam int STAT_FRESH_BIT   = 0;
   localparam int STAT_OVERRUN_BIT = 1;

endpackage

// File: rtl/lcb_uart_capture.sv
// lcb_uart_capture: synchronises ValRX, counts pulses within a UART frame
// window and captures one byte per window. A captured MARKER byte is
// replaced by a running event counter.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   ValRX         byte-valid level, asynchronous to clk
//   iUART[7:0]    received byte, stable while ValRX is high
//   capture       last captured value (CAP_W bits)
//   cap_stb       1-cycle pulse in the cycle the capture register loads
module lcb_uart_capture
   import lcb_answer_pkg::*;
#(
   parameter int         CAP_W      = 10,
   parameter int         FRAME_LEN  = 4,
   parameter int         SAMPLE_IDX = 1,
   parameter logic [7:0] MARKER     = 8'd82
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ValRX,
   input  logic [7:0]       iUART,
   output logic [CAP_W-1:0] capture,
   output logic             cap_stb
);

   localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   logic [1:0]       sync;
   logic             vs;
   cap_state_t       state, state_nxt;
   logic [IDX_W-1:0] idx;
   logic [CAP_W-1:0] ecnt;
   logic             in_sample;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= 2'b00;
      else     sync <= {sync[0], ValRX};
   end
   assign vs = sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (vs) state_nxt = SAMPLE;
         SAMPLE:   state_nxt = WAIT_LOW;
         WAIT_LOW: if (!vs) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   assign in_sample = (state == SAMPLE);
   // Strobe uses the pre-increment index, same edge that loads capture.
   assign cap_stb   = in_sample && (idx == IDX_W'(SAMPLE_IDX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx     <= '0;
         capture <= '0;
         ecnt    <= '0;
      end else if (in_sample) begin
         if (idx == IDX_W'(FRAME_LEN - 1)) idx <= '0;
         else                              idx <= idx + 1'b1;
         if (cap_stb) begin
            if (iUART == MARKER) begin
               capture <= ecnt;
               ecnt    <= ecnt + 1'b1;
            end else begin
               capture <= CAP_W'(iUART);
            end
         end
      end
   end

endmodule

// File: rtl/lcb_answer_table.sv
// lcb_answer_table: address-mapped answer generator for the LCB simulator.
// Slot 0 is a frame counter, slots 1..N_CONST a constant ramp (i*STEP),
// then CAP_LO / CAP_HI (UART-captured value) and STAT. Read data is
// registered: data reflects the addr presented one clk earlier.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   ValRX, iUART  UART receiver handshake and byte
//   addr          slot select, sampled every clk
//   data          registered slot contents
// Build option: define ANS_OVERRUN_EN to enable the fresh/overrun flags
// returned in STAT; otherwise STAT reads 0.
module lcb_answer_table
   import lcb_answer_pkg::*;
#(
   parameter int         DATA_W     = 8,
   parameter int         ADDR_W     = 5,
   parameter int         N_CONST    = 15,
   parameter int         STEP       = 10,
   parameter int         CAP_W      = 10,
   parameter int         FRAME_LEN  = 4,
   parameter int         SAMPLE_IDX = 1,
   parameter logic [7:0] MARKER     = 8'd82
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ValRX,
   input  logic [7:0]        iUART,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   localparam logic [ADDR_W-1:0] A_CAP_LO = ADDR_W'(N_CONST + CAP_LO_OFS);
   localparam logic [ADDR_W-1:0] A_CAP_HI = ADDR_W'(N_CONST + CAP_HI_OFS);
   localparam logic [ADDR_W-1:0] A_STAT   = ADDR_W'(N_CONST + STAT_OFS);

   logic [CAP_W-1:0]    capture;
   logic                cap_stb;
   logic [DATA_W-1:0]   fcnt;
   logic                armed;
   logic [DATA_W-1:0]   data_nxt;
   logic [2*DATA_W-1:0] cap_ext;
   logic [31:0]         a32;
   logic [31:0]         cval;
   logic [DATA_W-1:0]   stat;

   lcb_uart_capture #(
      .CAP_W      (CAP_W),
      .FRAME_LEN  (FRAME_LEN),
      .SAMPLE_IDX (SAMPLE_IDX),
      .MARKER     (MARKER)
   ) u_cap (
      .clk     (clk),
      .rst     (rst),
      .ValRX   (ValRX),
      .iUART   (iUART),
      .capture (capture),
      .cap_stb (cap_stb)
   );

`ifdef ANS_OVERRUN_EN
   logic fresh, overrun;

   // Capture (set) has priority over the read-side clears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fresh   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (cap_stb)               fresh <= 1'b1;
         else if (addr == A_CAP_HI) fresh <= 1'b0;
         if (cap_stb && fresh)      overrun <= 1'b1;
         else if (addr == A_STAT)   overrun <= 1'b0;
      end
   end

   always_comb begin
      stat                   = '0;
      stat[STAT_FRESH_BIT]   = fresh;
      stat[STAT_OVERRUN_BIT] = overrun;
   end
`else
   assign stat = '0;
`endif

   // Frame counter advances on the first CAP_HI read after visiting slot 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fcnt  <= '0;
         armed <= 1'b1;
      end else if (addr == '0) begin
         armed <= 1'b1;
      end else if (addr == A_CAP_HI && armed) begin
         fcnt  <= fcnt + 1'b1;
         armed <= 1'b0;
      end
   end

   always_comb begin
      cap_ext              = '0;
      cap_ext[CAP_W-1:0]   = capture;
      a32                  = 32'(addr);
      cval                 = a32 * 32'(STEP);
      data_nxt             = '0;
      if (addr == '0)                 data_nxt = fcnt;
      else if (a32 <= 32'(N_CONST))   data_nxt = cval[DATA_W-1:0];
      else if (addr == A_CAP_LO)      data_nxt = cap_ext[DATA_W-1:0];
      else if (addr == A_CAP_HI)      data_nxt = cap_ext[2*DATA_W-1:DATA_W];
      else if (addr == A_STAT)        data_nxt = stat;
   end

   // Capture register loads on the same edge, so a simultaneous read
   // returns the pre-capture value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) data <= '0;
      else     data <= data_nxt;
   end

endmodule

// File: tb/tb_lcb_answer_table.sv
module tb_lcb_answer_table;

   localparam int A_PARK = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ValRX = 1'b0;
   logic [7:0] iUART = 8'h00;
   logic [4:0] addr = 5'd20;
   logic [7:0] data;

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_q[$];
   string      tag_q[$];
   logic [7:0] e;
   string      t;

   lcb_answer_table dut (
      .clk   (clk),
      .rst   (rst),
      .ValRX (ValRX),
      .iUART (iUART),
      .addr  (addr),
      .data  (data)
   );

   always #5 clk = ~clk;

   // Drive addr at a negedge and record what must appear one clk later.
   task automatic issue(input int a, input logic [7:0] x, input string nm);
      addr = 5'(a);
      exp_q.push_back(x);
      tag_q.push_back(nm);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; ValRX = 1'b0; addr = 5'(A_PARK);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse(input logic [7:0] b);
      iUART = b;
      ValRX = 1'b1;
      repeat (5) @(negedge clk);
      ValRX = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      issue(3, 8'd30, "pre_reset_slot3");
      @(negedge clk);
      e = exp_q.pop_front(); t = tag_q.pop_front(); tests++;
      if (data !== e) begin fails++; $display("FAIL %s: got %0h want %0h", t, data, e); end
      #1 rst = 1'b1;
      #1 tests++;
      if (data !== 8'd0) begin fails++; $display("FAIL async_reset_data: got %0h want 0", data); end
      @(negedge clk);
      rst = 1'b0;
      issue(0, 8'd0, "reset_fcnt");
      @(negedge clk);
      e = exp_q.pop_front(); t = tag_q.pop_front(); tests++;
      if (data !== e) begin fails++; $display("FAIL %s: got %0h want %0h", t, data, e); end
   endtask

   task automatic test_sweep();
      logic [7:0] x;
      do_reset();
      for (int a = 0; a <= 19; a++) begin
         if (a >= 1 && a <= 15) x = 8'(a * 10);
         else                   x = 8'd0;
         issue(a, x, $sformatf("sweep_addr%0d", a));
         @(negedge clk);
         e = exp_q.pop_front(); t = tag_q.pop_front(); tests++;
         if (data !== e) begin fails++; $display("FAIL %s: got %0h want %0h", t, data, e); end
      end
      issue(31, 8'd0, "sweep_addr31");
      @(negedge clk);
      e = exp_q.pop_front(); t = tag_q.pop_front(); tests++;
      if (data !== e) begin fails++; $display("FAIL %s: got %0h want %0h", t, data, e); end
   endtask

   task automatic test_capture();
      do_reset();
      pulse(8'h11); pulse(8'h22); pulse(8'h33); pulse(8'h44);
      issue(16, 8'h22, "cap_lo_window");
      @(negedge clk);
      e = exp_q.pop_front(); t = tag_q.pop_front(); tests++;
      if (data !== e) begin fails++; $display("FAIL %s: got %0h want %0h", t, data, e); end
      issue(17, 8'h00, "cap_hi_window");
      @(negedge clk);
      e = exp_q.pop_front(); t = tag_q.pop_front(); tests++;
      if (data !== e) begin fails++; $display("FAIL %s: got %0h want %0h", t, data, e); end
      addr = 5'(A_PARK);
   endtask

   task automatic test_marker();
      logic [7:0] want [4];
      logic [7:0] byt  [4];
      want = '{8'h00, 8'h01, 8'h5A, 8'h02};
      byt  = '{8'd82, 8'd82, 8'h5A, 8'd82};
      do_reset();
      for (int w = 0; w < 4; w++) begin
         pulse(8'h10 + 8'(w)); pulse(byt[w]); pulse(8'h77); pulse(8'd82 + 8'd1);
         issue(16, want[w], $sformatf("marker_win%0d", w));
         @(negedge clk);
         e = exp_q.pop_front(); t = tag_q.pop_front(); tests++;
         if (data !== e) begin fails++; $display("FAIL %s: got %0h want %0h", t, data, e); end
         addr = 5'(A_PARK);
      end
   endtask

   task automatic test_frame_counter();
      int         seq  [6];
      logic [7:0] want [6];
      seq  = '{0, 17, 17, 0, 17, 0};
      want = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd2};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         issue(seq[i], want[i], $sformatf("fcnt_step%0d", i));
         @(negedge clk);
         e = exp_q.pop_front(); t = tag_q.pop_front(); tests++;
         if (data !== e) begin fails++; $display("FAIL %s: got %0h want %0h", t, data, e); end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] m = 8'd0;
      do_reset();
      for (int i = 0; i < 256; i++) begin
         issue(0, m, $sformatf("wrap_rd%0d", i));
         @(negedge clk);
         e = exp_q.pop_front(); t = tag_q.pop_front(); tests++;
         if (data !== e) begin fails++; $display("FAIL %s: got %0h want %0h", t, data, e); end
         issue(17, 8'd0, "wrap_hi");
         m = m + 8'd1;
         @(negedge clk);
         e = exp_q.pop_front(); t = tag_q.pop_front(); tests++;
         if (data !== e) begin fails++; $display("FAIL %s: got %0h want %0h", t, data, e); end
      end
      issue(0, 8'd0, "wrap_final");
      @(negedge clk);
      e = exp_q.pop_front(); t = tag_q.pop_front(); tests++;
      if (data !== e) begin fails++; $display("FAIL %s: got %0h want %0h", t, data, e); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      iUART = 8'hEE;
      ValRX = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      ValRX = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      pulse(8'hA1); pulse(8'hB2);
      issue(16, 8'hB2, "mid_reset_idx");
      @(negedge clk);
      e = exp_q.pop_front(); t = tag_q.pop_front(); tests++;
      if (data !== e) begin fails++; $display("FAIL %s: got %0h want %0h", t, data, e); end
      addr = 5'(A_PARK);
   endtask

   task automatic test_stat();
`ifdef ANS_OVERRUN_EN
      int         seq  [4];
      logic [7:0] want [4];
      seq  = '{18, 18, 17, 18};
      want = '{8'h03, 8'h01, 8'h00, 8'h00};
`else
      int         seq  [2];
      logic [7:0] want [2];
      seq  = '{18, 17};
      want = '{8'h00, 8'h00};
`endif
      do_reset();
      for (int w = 0; w < 2; w++) begin
         pulse(8'h01); pulse(8'h40 + 8'(w)); pulse(8'h02); pulse(8'h03);
      end
      foreach (seq[i]) begin
         issue(seq[i], want[i], $sformatf("stat_step%0d", i));
         @(negedge clk);
         e = exp_q.pop_front(); t = tag_q.pop_front(); tests++;
         if (data !== e) begin fails++; $display("FAIL %s: got %0h want %0h", t, data, e); end
      end
      addr = 5'(A_PARK);
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_capture();
      test_marker();
      test_frame_counter();
      test_wrap();
      test_mid_reset();
      test_stat();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lcb_answer_table.md
Name: lcb_answer_table

Overview:
- Parametrised address-mapped answer generator for the LCB simulator. Successor to the fixed 18-slot responder.
- Returns a frame counter, a programmable ramp of constant words and a UART-captured value, all from a registered read port.
- Captures one byte per UART frame window, with marker-byte substitution by an event counter.
- Sits between the UART receiver (ValRX/iUART) and the telemetry frame builder, which scans addr.

Parameters:
- DATA_W, 8, read data width.
- ADDR_W, 5, address width.
- N_CONST, 15, number of constant slots (addresses 1..N_CONST).
- STEP, 10, constant slot i returns i*STEP truncated to DATA_W.
- CAP_W, 10, captured value width; DATA_W < CAP_W <= 2*DATA_W.
- FRAME_LEN, 4, ValRX pulses per UART frame window.
- SAMPLE_IDX, 1, pulse index within the window that is captured; must be < FRAME_LEN.
- MARKER, 8'd82, byte that is replaced by the event counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ValRX  in  1  UART byte-valid level, asynchronous to clk.
- iUART  in  8  received byte; stable while ValRX is high.
- addr  in  ADDR_W  slot select, sampled every clk.
- data  out  DATA_W  registered slot contents.

Behaviour:
- Reset (asynchronous, rst=1):
  - data=0, frame counter=0, armed=1, FSM=IDLE, pulse index=0, capture=0, event counter=0, ValRX synchroniser=2'b00.
- ValRX synchroniser:
  - 2-flop synchroniser; vs is the second stage.
- Capture FSM:
  - IDLE: vs=1 -> SAMPLE.
  - SAMPLE (exactly 1 cycle): always -> WAIT_LOW.
    - The pulse index increments and wraps FRAME_LEN-1 -> 0.
    - If the pre-increment index == SAMPLE_IDX, a capture occurs: iUART==MARKER -> capture <= event counter, event counter += 1 (CAP_W bits, wraps); otherwise capture <= zero-extended iUART.
  - WAIT_LOW: vs=0 -> IDLE.
  - A pulse shorter than the synchroniser delay may be missed. This is accepted.
- Address map (data updates on the clk after addr; latency 1):
  - 0: frame counter; sets armed=1.
  - 1..N_CONST: i*STEP mod 2^DATA_W.
  - N_CONST+1 (CAP_LO): capture[DATA_W-1:0].
  - N_CONST+2 (CAP_HI): capture[CAP_W-1:DATA_W], zero-extended. If armed: frame counter += 1 (wraps 2^DATA_W -> 0) and armed=0.
  - N_CONST+3 (STAT): see Optional Feature.
  - Any other address: data=0.
- Frame counter increments at most once per visit to address 0; holding addr on CAP_HI does not re-increment.
- Simultaneous capture and read of a capture slot: data returns the pre-capture value. The new value is visible on the next read.
- Reset mid-frame: the FSM, pulse index and counters return to reset values immediately; a partially seen pulse is discarded.

Optional Feature:
- Macro ANS_OVERRUN_EN.
- With the macro: STAT returns {0…, overrun, fresh}.
  - fresh: set on capture, cleared on a CAP_HI read.
  - overrun: sticky; set when a capture occurs while fresh=1.
  - A STAT read returns the pre-clear value, then clears overrun.
  - Capture and clear in the same cycle: set wins.
- Without the macro: STAT returns 0 and no flag registers exist.

Decomposition:
- Package lcb_answer_pkg holds:
  - the FSM state enum (IDLE, SAMPLE, WAIT_LOW);
  - the slot-offset constants CAP_LO_OFS=1, CAP_HI_OFS=2, STAT_OFS=3, all relative to N_CONST;
  - STAT bit indices.
- One sub-module, lcb_uart_capture: synchroniser, FSM, pulse index, marker logic and event counter. It outputs capture[CAP_W-1:0] and a 1-cycle cap_stb.
- The top module keeps the address decode and the frame counter.

Test Plan:
- Reset, then addr sweep 0..17 -> data = 0, 10, 20, …, 150, 0, 0, each one clk after its addr.
- Four ValRX pulses with iUART = 0x11, 0x22, 0x33, 0x44 -> CAP_LO=0x22, CAP_HI=0. No other byte captured.
- Two windows, each capturing the MARKER byte 82 -> captures 0 then 1 (CAP_LO=0x01); event counter=2.
- Sequence addr 0 -> 17 -> 17 -> 0 -> 17 -> frame counter reads 0, then 1 on the second addr-0 read; the repeated 17 adds nothing.
- Counter wrap: 256 addr-0/17 cycles -> addr 0 reads 0 again.
- ANS_OVERRUN_EN: two captures with no CAP_HI read -> STAT=0x03. Second STAT read -> 0x01. After a CAP_HI read -> 0x00.
